ex_lsu_axi: RTL and testbench

Execute-stage load/store unit, directly downstream of the ID→EX pipeline register. It consumes that register's read_ram/write_ram, AXI address, operand and instruction fields. It runs one AXI4-Lite single-beat transaction on a 64-bit data bus. It holds the pipeline via a stall request to ctrl until the access completes, then returns the aligned, extended load data and its destination register.

---
 rtl/ex_lsu_axi.sv | 224 ++++++++++++++++++++++
 tb/tb_ex_lsu_axi.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_lsu_axi.sv
// Execute-stage load/store unit: one AXI4-Lite single-beat access per request on a 64-bit bus,
// stalling the pipeline until the access completes and returning aligned, extended load data.
module ex_lsu_axi #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_ram_i,
  input  logic        write_ram_i,
  input  logic [31:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_addr_i,
  output logic        hold_flag_o,
  output logic        ld_valid_o,
  output logic [63:0] ld_data_o,
  output logic [4:0]  ld_rd_addr_o,
  output logic        err_o,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [63:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAww, StB, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      wstrb_q, wstrb_d;
  logic            arvalid_q, arvalid_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            ld_valid_q, ld_valid_d;
  logic            err_q, err_d;
  logic [63:0]     ld_data_q, ld_data_d;
  logic [4:0]      ld_rd_q, ld_rd_d;

  logic        req, busy, timeout, misaligned, aw_ok, w_ok;
  logic [2:0]  size_mask;
  logic [7:0]  strb_base;
  logic [63:0] rshift, ld_ext;

  always_comb begin
    req  = read_ram_i | write_ram_i;
    busy = (state_q == StAr) | (state_q == StR) | (state_q == StAww) | (state_q == StB);
    timeout = busy & (cnt_q == CntLast);
    case (funct3_i[1:0])
      2'b00:   begin size_mask = 3'b000; strb_base = 8'h01; end
      2'b01:   begin size_mask = 3'b001; strb_base = 8'h03; end
      2'b10:   begin size_mask = 3'b011; strb_base = 8'h0F; end
      default: begin size_mask = 3'b111; strb_base = 8'hFF; end
    endcase
    misaligned = |(addr_i[2:0] & size_mask);
    rshift = m_rdata >> {addr_q[2:0], 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{56{rshift[7]}}, rshift[7:0]};
      3'b001:  ld_ext = {{48{rshift[15]}}, rshift[15:0]};
      3'b010:  ld_ext = {{32{rshift[31]}}, rshift[31:0]};
      3'b100:  ld_ext = {56'b0, rshift[7:0]};
      3'b101:  ld_ext = {48'b0, rshift[15:0]};
      3'b110:  ld_ext = {32'b0, rshift[31:0]};
      default: ld_ext = rshift;
    endcase
    // A channel whose valid has already dropped counts as handshaken.
    aw_ok = ~awvalid_q | m_awready;
    w_ok  = ~wvalid_q | m_wready;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    arvalid_d  = arvalid_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    ld_valid_d = 1'b0;
    err_d      = 1'b0;
    ld_data_d  = ld_data_q;
    ld_rd_d    = ld_rd_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          addr_d   = addr_i;
          funct3_d = funct3_i;
          rd_d     = rd_addr_i;
          wdata_d  = wdata_i << {addr_i[2:0], 3'b000};
          wstrb_d  = strb_base << addr_i[2:0];
          if (misaligned) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else if (read_ram_i) begin
            state_d   = StAr;
            arvalid_d = 1'b1;
          end else begin
            state_d   = StAww;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      StAr: begin
        if (m_arready) begin
          state_d   = StR;
          arvalid_d = 1'b0;
        end else if (timeout) begin
          state_d   = StDone;
          arvalid_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      StR: begin
        if (m_rvalid) begin
          state_d = StDone;
          if (m_rresp == 2'b00) begin
            ld_valid_d = 1'b1;
            ld_data_d  = ld_ext;
            ld_rd_d    = rd_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StAww: begin
        if (m_awready) awvalid_d = 1'b0;
        if (m_wready) wvalid_d = 1'b0;
        if (aw_ok && w_ok) begin
          state_d = StB;
        end else if (timeout) begin
          state_d   = StDone;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          err_d     = 1'b1;
        end
      end
      StB: begin
        if (m_bvalid) begin
          state_d = StDone;
          err_d   = (m_bresp != 2'b00);
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    cnt_d = ((state_d != state_q) || !busy) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      ld_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ld_data_q  <= '0;
      ld_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      arvalid_q  <= arvalid_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      ld_valid_q <= ld_valid_d;
      err_q      <= err_d;
      ld_data_q  <= ld_data_d;
      ld_rd_q    <= ld_rd_d;
    end
  end

  assign hold_flag_o  = busy | ((state_q == StIdle) & req);
  assign ld_valid_o   = ld_valid_q;
  assign err_o        = err_q;
  assign ld_data_o    = ld_data_q;
  assign ld_rd_addr_o = ld_rd_q;
  assign m_araddr     = {addr_q[31:3], 3'b000};
  assign m_awaddr     = {addr_q[31:3], 3'b000};
  assign m_arvalid    = arvalid_q;
  assign m_rready     = (state_q == StR);
  assign m_awvalid    = awvalid_q;
  assign m_wvalid     = wvalid_q;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = wstrb_q;
  assign m_bready     = (state_q == StB);

endmodule

// File: tb/tb_ex_lsu_axi.sv
// Bench for ex_lsu_axi: latency-configurable AXI4-Lite slave plus a scoreboard of expected
// load/error pulses checked whenever the unit signals completion.
module tb_ex_lsu_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_ram_i, write_ram_i;
  logic [31:0] addr_i;
  logic [63:0] wdata_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_addr_i;
  logic        hold_flag_o, ld_valid_o, err_o;
  logic [63:0] ld_data_o;
  logic [4:0]  ld_rd_addr_o;
  logic [31:0] m_araddr, m_awaddr;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [63:0] m_rdata, m_wdata;
  logic [1:0]  m_rresp, m_bresp;
  logic [7:0]  m_wstrb;

  always #5 clk = ~clk;

  ex_lsu_axi #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .read_ram_i(read_ram_i), .write_ram_i(write_ram_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .funct3_i(funct3_i), .rd_addr_i(rd_addr_i), .hold_flag_o(hold_flag_o),
    .ld_valid_o(ld_valid_o), .ld_data_o(ld_data_o), .ld_rd_addr_o(ld_rd_addr_o), .err_o(err_o),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave configuration and observed traffic
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic        r_pend, aw_seen, w_seen, b_pend;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_arv = 0, n_brdy = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0;
  logic [63:0] cap_wdata = '0;
  logic [7:0]  cap_wstrb = '0;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign m_arready = m_arvalid && (ar_cnt >= ar_lat);
  assign m_awready = m_awvalid && (aw_cnt >= aw_lat);
  assign m_wready  = m_wvalid && (w_cnt >= w_lat);
  assign m_rvalid  = r_pend && (r_cnt >= r_lat);
  assign m_bvalid  = b_pend && (b_cnt >= b_lat);
  assign m_rdata   = cfg_rdata;
  assign m_rresp   = m_rvalid ? cfg_rresp : 2'b00;
  assign m_bresp   = m_bvalid ? cfg_bresp : 2'b00;
  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid && m_rready;
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign b_hs  = m_bvalid && m_bready;

  always @(posedge clk) begin
    if (rst) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0;
    end else begin
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      r_cnt  <= (r_pend && !r_hs) ? r_cnt + 1 : 0;
      b_cnt  <= (b_pend && !b_hs) ? b_cnt + 1 : 0;
      if (ar_hs) begin r_pend <= 1'b1; n_ar <= n_ar + 1; cap_araddr <= m_araddr; end
      if (r_hs) r_pend <= 1'b0;
      if (aw_hs) begin n_aw <= n_aw + 1; cap_awaddr <= m_awaddr; end
      if (w_hs) begin n_w <= n_w + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
      if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
        b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= aw_seen || aw_hs; w_seen <= w_seen || w_hs;
      end
      if (b_hs) begin b_pend <= 1'b0; n_b <= n_b + 1; end
      if (m_arvalid) n_arv <= n_arv + 1;
      if (m_bready) n_brdy <= n_brdy + 1;
    end
  end

  typedef struct {logic err; logic [63:0] data; logic [4:0] rd;} exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (!rst && (ld_valid_o || err_o)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", {62'b0, ld_valid_o, err_o}, 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_err", {63'b0, err_o}, {63'b0, sb_e.err});
        check("sb_valid", {63'b0, ld_valid_o}, {63'b0, !sb_e.err});
        if (!sb_e.err) begin
          check("sb_data", ld_data_o, sb_e.data);
          check("sb_rd", {59'b0, ld_rd_addr_o}, {59'b0, sb_e.rd});
        end
      end
    end
  end

  task automatic push(input logic err, input logic [63:0] data, input logic [4:0] rd);
    exp_t e;
    e.err = err; e.data = data; e.rd = rd;
    sb_q.push_back(e);
  endtask

  // Holds the request until hold_flag_o drops; reports stall cycles and the DONE-cycle pulses.
  task automatic run_req(input logic rr, input logic wr, input logic [31:0] a,
                         input logic [63:0] wd, input logic [2:0] f3, input logic [4:0] rd,
                         output int hold_cyc, output logic lv, output logic er);
    bit done = 0;
    read_ram_i = rr; write_ram_i = wr; addr_i = a; wdata_i = wd; funct3_i = f3; rd_addr_i = rd;
    hold_cyc = 0; lv = 1'b0; er = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!hold_flag_o) begin
        done = 1;
        lv = ld_valid_o;
        er = err_o;
      end else begin
        hold_cyc++;
        @(posedge clk); #1;
      end
    end
    if (!done) check("hold_bound_expired", 64'd1, 64'd0);
    read_ram_i = 1'b0; write_ram_i = 1'b0;
    @(posedge clk); #1;
  endtask

  int   hc, ar0, aw0, w0, b0, arv0, brdy0;
  logic lv, er;

  task automatic snap();
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b; arv0 = n_arv; brdy0 = n_brdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; read_ram_i = 1'b0; write_ram_i = 1'b0; addr_i = '0; wdata_i = '0;
    funct3_i = '0; rd_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {63'b0, hold_flag_o}, 64'd0);
    check("rst_outs", {57'b0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, ld_valid_o,
                       err_o}, 64'd0);
    check("rst_ld_data", ld_data_o, 64'd0);
    check("rst_wstrb", {56'b0, m_wstrb}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LD, zero-wait slave
    cfg_rdata = 64'h1122334455667788;
    snap();
    push(1'b0, 64'h1122334455667788, 5'd5);
    run_req(1'b1, 1'b0, 32'h80000010, '0, 3'b011, 5'd5, hc, lv, er);
    check("ld_hold", hc, 3);
    check("ld_pulse", {62'b0, lv, er}, 64'd2);
    check("ld_araddr", {32'b0, cap_araddr}, 64'h80000010);
    check("ld_nar", n_ar - ar0, 1);
    check("ld_retain", ld_data_o, 64'h1122334455667788);

    // LB / LBU from top byte
    cfg_rdata = 64'h80AA_BBCC_DDEE_FF11;
    push(1'b0, 64'hFFFFFFFFFFFFFF80, 5'd7);
    run_req(1'b1, 1'b0, 32'h80000007, '0, 3'b000, 5'd7, hc, lv, er);
    check("lb_araddr", {32'b0, cap_araddr}, 64'h80000000);
    push(1'b0, 64'h0000000000000080, 5'd8);
    run_req(1'b1, 1'b0, 32'h80000007, '0, 3'b100, 5'd8, hc, lv, er);

    // LW / LWU upper word, slow read data
    cfg_rdata = 64'h87654321_00000000;
    r_lat = 2;
    push(1'b0, 64'hFFFFFFFF87654321, 5'd9);
    run_req(1'b1, 1'b0, 32'h80000004, '0, 3'b010, 5'd9, hc, lv, er);
    check("lw_hold_wait", hc, 5);
    push(1'b0, 64'h0000000087654321, 5'd10);
    run_req(1'b1, 1'b0, 32'h80000004, '0, 3'b110, 5'd10, hc, lv, er);
    r_lat = 0;

    // SH with awready two cycles ahead of wready, delayed bvalid
    aw_lat = 1; w_lat = 3; b_lat = 2;
    snap();
    run_req(1'b0, 1'b1, 32'h80000006, 64'h000000000000ABCD, 3'b001, 5'd0, hc, lv, er);
    check("sh_wstrb", {56'b0, cap_wstrb}, 64'hC0);
    check("sh_wdata_hi", {48'b0, cap_wdata[63:48]}, 64'hABCD);
    check("sh_awaddr", {32'b0, cap_awaddr}, 64'h80000000);
    check("sh_hs", {32'(n_aw - aw0), 32'(n_w - w0)}, {32'd1, 32'd1});
    check("sh_nb", n_b - b0, 1);
    check("sh_bready_cyc", n_brdy - brdy0, 3);
    check("sh_hold", hc, 8);
    check("sh_no_pulse", {62'b0, lv, er}, 64'd0);
    aw_lat = 0; w_lat = 0; b_lat = 0;

    // SD, same-cycle AW/W handshake
    snap();
    run_req(1'b0, 1'b1, 32'h80000018, 64'hDEADBEEF_CAFEF00D, 3'b011, 5'd0, hc, lv, er);
    check("sd_hold", hc, 3);
    check("sd_wstrb", {56'b0, cap_wstrb}, 64'hFF);
    check("sd_wdata", cap_wdata, 64'hDEADBEEF_CAFEF00D);
    check("sd_nb", n_b - b0, 1);

    // Misaligned LW: error, no bus activity
    snap();
    push(1'b1, '0, 5'd0);
    run_req(1'b1, 1'b0, 32'h80000002, '0, 3'b010, 5'd11, hc, lv, er);
    check("mis_hold", hc, 1);
    check("mis_pulse", {62'b0, lv, er}, 64'd1);
    check("mis_arv", n_arv - arv0, 0);

    // AR timeout
    ar_lat = 1000;
    snap();
    push(1'b1, '0, 5'd0);
    run_req(1'b1, 1'b0, 32'h80000008, '0, 3'b011, 5'd12, hc, lv, er);
    check("to_arv_cyc", n_arv - arv0, 8);
    check("to_hold", hc, 9);
    check("to_pulse", {62'b0, lv, er}, 64'd1);
    check("to_idle_arvalid", {63'b0, m_arvalid}, 64'd0);
    ar_lat = 0;

    // Error read response
    cfg_rresp = 2'b10;
    push(1'b1, '0, 5'd0);
    run_req(1'b1, 1'b0, 32'h80000008, '0, 3'b011, 5'd13, hc, lv, er);
    check("rresp_pulse", {62'b0, lv, er}, 64'd1);
    check("rresp_retain", ld_data_o, 64'h0000000087654321);
    cfg_rresp = 2'b00;

    // Reset while waiting in R
    r_lat = 1000;
    read_ram_i = 1'b1; addr_i = 32'h80000010; funct3_i = 3'b011; rd_addr_i = 5'd14;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_r_rready", {63'b0, m_rready}, 64'd1);
    read_ram_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_outs", {56'b0, hold_flag_o, m_arvalid, m_awvalid, m_wvalid, m_rready,
                           m_bready, ld_valid_o, err_o}, 64'd0);
    check("mid_rst_data", ld_data_o, 64'd0);
    rst = 1'b0; r_lat = 0;
    @(posedge clk); #1;

    // Both requests: the read wins, the write is dropped
    cfg_rdata = 64'h0123456789ABCDEF;
    snap();
    push(1'b0, 64'h0123456789ABCDEF, 5'd15);
    run_req(1'b1, 1'b1, 32'h80000020, 64'h5555, 3'b011, 5'd15, hc, lv, er);
    check("both_ar", n_ar - ar0, 1);
    check("both_no_aw_w", {32'(n_aw - aw0), 32'(n_w - w0)}, 64'd0);
    check("both_hold", hc, 3);

    repeat (2) @(posedge clk);
    #1;
    check("sb_leftover", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
